// File: rtl/rgb_fade_sequencer.sv
// RGB LED colour sequencer: walks a fixed palette, jumping or fading linearly between
// colours, holding each for a number of ticks, and drives three registered PWM outputs.
module rgb_fade_sequencer #(
  parameter int DUTY_W     = 8,
  parameter int NUM_COLORS = 6,
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fade_en,
  input  logic              step_req,
  output logic [2:0]        state,
  output logic [DUTY_W-1:0] R_time_out,
  output logic [DUTY_W-1:0] G_time_out,
  output logic [DUTY_W-1:0] B_time_out,
  output logic              pwm_r,
  output logic              pwm_g,
  output logic              pwm_b,
  output logic              at_target
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [2:0]        LAST_COLOR = 3'(NUM_COLORS - 1);
  localparam logic [DUTY_W-1:0] PWM_MAX    = {{(DUTY_W-1){1'b1}}, 1'b0};

  typedef enum logic {ST_HOLD = 1'b0, ST_FADE = 1'b1} fsm_t;

  function automatic logic [23:0] palette8(input logic [2:0] idx);
    case (idx)
      3'd0:    palette8 = 24'hff0000;
      3'd1:    palette8 = 24'hff6100;
      3'd2:    palette8 = 24'hffff00;
      3'd3:    palette8 = 24'h00ff00;
      3'd4:    palette8 = 24'h0000ff;
      3'd5:    palette8 = 24'h7f1fff;
      default: palette8 = 24'h000000;
    endcase
  endfunction

  // Full-scale 8-bit value must stay full-scale at wider resolutions.
  function automatic logic [DUTY_W-1:0] scale(input logic [7:0] v);
    if (v == 8'hff) scale = {DUTY_W{1'b1}};
    else            scale = DUTY_W'(v) << (DUTY_W - 8);
  endfunction

  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    if (cur < tgt)      step_toward = cur + DUTY_W'(1);
    else if (cur > tgt) step_toward = cur - DUTY_W'(1);
    else                step_toward = cur;
  endfunction

  logic [2:0]        r_state;
  logic [DUTY_W-1:0] r_duty_r, r_duty_g, r_duty_b;
  fsm_t              r_fsm;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DUTY_W-1:0] r_pwm_cnt;
  logic [DUTY_W-1:0] r_cmp_r, r_cmp_g, r_cmp_b;
  logic              r_pwm_r, r_pwm_g, r_pwm_b;

  logic              w_tick, w_hold_done, w_advance, w_step_done;
  logic [2:0]        w_next_state;
  logic [23:0]       w_tgt8, w_nxt8;
  logic [DUTY_W-1:0] w_tgt_r, w_tgt_g, w_tgt_b;
  logic [DUTY_W-1:0] w_nxt_r, w_nxt_g, w_nxt_b;
  logic [DUTY_W-1:0] w_step_r, w_step_g, w_step_b;

  assign w_tick       = en && (r_div_cnt == DIV_LAST);
  assign w_hold_done  = (r_fsm == ST_HOLD) && w_tick && (r_hold_cnt == HOLD_LAST);
  assign w_advance    = step_req || w_hold_done;
  assign w_next_state = (r_state == LAST_COLOR) ? 3'd0 : r_state + 3'd1;

  assign w_tgt8  = palette8(r_state);
  assign w_nxt8  = palette8(w_next_state);
  assign w_tgt_r = scale(w_tgt8[23:16]);
  assign w_tgt_g = scale(w_tgt8[15:8]);
  assign w_tgt_b = scale(w_tgt8[7:0]);
  assign w_nxt_r = scale(w_nxt8[23:16]);
  assign w_nxt_g = scale(w_nxt8[15:8]);
  assign w_nxt_b = scale(w_nxt8[7:0]);

  assign w_step_r    = step_toward(r_duty_r, w_tgt_r);
  assign w_step_g    = step_toward(r_duty_g, w_tgt_g);
  assign w_step_b    = step_toward(r_duty_b, w_tgt_b);
  assign w_step_done = (w_step_r == w_tgt_r) && (w_step_g == w_tgt_g) && (w_step_b == w_tgt_b);

  // Tick prescaler, parked at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div_cnt <= '0;
    else if (!en)    r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  // Hold/fade sequencer; an advance takes priority over any fade step in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= 3'd0;
      r_duty_r   <= scale(8'hff);
      r_duty_g   <= scale(8'h00);
      r_duty_b   <= scale(8'h00);
      r_fsm      <= ST_HOLD;
      r_hold_cnt <= '0;
    end else if (w_advance) begin
      r_state    <= w_next_state;
      r_hold_cnt <= '0;
      if (fade_en) begin
        r_fsm <= ST_FADE;
      end else begin
        r_fsm    <= ST_HOLD;
        r_duty_r <= w_nxt_r;
        r_duty_g <= w_nxt_g;
        r_duty_b <= w_nxt_b;
      end
    end else if (w_tick) begin
      case (r_fsm)
        ST_HOLD: r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        ST_FADE: begin
          if (!fade_en) begin
            r_duty_r   <= w_tgt_r;
            r_duty_g   <= w_tgt_g;
            r_duty_b   <= w_tgt_b;
            r_fsm      <= ST_HOLD;
            r_hold_cnt <= '0;
          end else begin
            r_duty_r <= w_step_r;
            r_duty_g <= w_step_g;
            r_duty_b <= w_step_b;
            if (w_step_done) begin
              r_fsm      <= ST_HOLD;
              r_hold_cnt <= '0;
            end
          end
        end
        default: r_fsm <= ST_HOLD;
      endcase
    end
  end

  // PWM counter and comparators; duties are latched once per period at the counter's last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_cmp_r   <= '0;
      r_cmp_g   <= '0;
      r_cmp_b   <= '0;
      r_pwm_r   <= 1'b0;
      r_pwm_g   <= 1'b0;
      r_pwm_b   <= 1'b0;
    end else begin
      r_pwm_r <= (r_pwm_cnt < r_cmp_r);
      r_pwm_g <= (r_pwm_cnt < r_cmp_g);
      r_pwm_b <= (r_pwm_cnt < r_cmp_b);
      if (r_pwm_cnt == PWM_MAX) begin
        r_pwm_cnt <= '0;
        r_cmp_r   <= r_duty_r;
        r_cmp_g   <= r_duty_g;
        r_cmp_b   <= r_duty_b;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
      end
    end
  end

  assign state      = r_state;
  assign R_time_out = r_duty_r;
  assign G_time_out = r_duty_g;
  assign B_time_out = r_duty_b;
  assign pwm_r      = r_pwm_r;
  assign pwm_g      = r_pwm_g;
  assign pwm_b      = r_pwm_b;
  assign at_target  = (r_duty_r == w_tgt_r) && (r_duty_g == w_tgt_g) && (r_duty_b == w_tgt_b);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer with DUTY_W=8, TICK_DIV=2, HOLD_TICKS=3; expected colours and
// fade values are queued when stimulus is applied and compared as the DUT reaches them.
module tb_rgb_fade_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       fade_en = 1'b0;
  logic       step_req = 1'b0;
  logic [2:0] state;
  logic [7:0] R_time_out, G_time_out, B_time_out;
  logic       pwm_r, pwm_g, pwm_b;
  logic       at_target;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  st;
    logic [23:0] rgb;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rq[$];
  logic [23:0] pal [6] = '{24'hff0000, 24'hff6100, 24'hffff00, 24'h00ff00, 24'h0000ff, 24'h7f1fff};

  rgb_fade_sequencer #(
    .DUTY_W(8), .NUM_COLORS(6), .TICK_DIV(2), .HOLD_TICKS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fade_en(fade_en), .step_req(step_req),
    .state(state), .R_time_out(R_time_out), .G_time_out(G_time_out), .B_time_out(B_time_out),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .at_target(at_target)
  );

  always #5 clk = ~clk;

  task automatic step_pulse;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
  endtask

  task automatic test_reset;
    int hr, hg, hb;
    rst_n = 1'b0; en = 1'b0; fade_en = 1'b0; step_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++;
    if ({R_time_out, G_time_out, B_time_out} !== 24'hff0000) begin
      n_fail++; $display("FAIL reset_duty got %h want ff0000", {R_time_out, G_time_out, B_time_out});
    end
    n_checks++;
    if (at_target !== 1'b1) begin n_fail++; $display("FAIL reset_at_target got %b want 1", at_target); end
    n_checks++;
    if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pwm got %b want 000", {pwm_r, pwm_g, pwm_b});
    end
    rst_n = 1'b1;
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
    end
    n_checks++;
    if (hr + hg + hb != 0) begin n_fail++; $display("FAIL first_period_pwm got %0d/%0d/%0d want 0/0/0", hr, hg, hb); end
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
    end
    n_checks++;
    if (hr != 255 || hg != 0 || hb != 0) begin
      n_fail++; $display("FAIL second_period_pwm got %0d/%0d/%0d want 255/0/0", hr, hg, hb);
    end
  endtask

  task automatic test_jump;
    exp_t       e;
    int         since;
    logic [2:0] prev;
    for (int i = 1; i <= 6; i++) begin
      e.st  = 3'(i % 6);
      e.rgb = pal[i % 6];
      sb.push_back(e);
    end
    fade_en = 1'b0;
    en = 1'b1;
    since = 0;
    prev = state;
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      @(negedge clk);
      since++;
      if (state !== prev) begin
        e = sb.pop_front();
        n_checks++;
        if (state !== e.st || {R_time_out, G_time_out, B_time_out} !== e.rgb) begin
          n_fail++;
          $display("FAIL jump_colour got %0d:%h want %0d:%h", state, {R_time_out, G_time_out, B_time_out}, e.st, e.rgb);
        end
        n_checks++;
        if (since != 6) begin n_fail++; $display("FAIL jump_interval got %0d want 6", since); end
        since = 0;
        prev = state;
      end
    end
    en = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL jump_timeout got %0d pending want 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_fade;
    logic [7:0] prev_r, exp_r;
    int         t_at, t_adv;
    fade_en = 1'b0;
    step_pulse();
    step_pulse();
    n_checks++;
    if (state !== 3'd2 || {R_time_out, G_time_out, B_time_out} !== 24'hffff00) begin
      n_fail++; $display("FAIL fade_setup got %0d:%h want 2:ffff00", state, {R_time_out, G_time_out, B_time_out});
    end
    fade_en = 1'b1;
    step_pulse();
    n_checks++;
    if (state !== 3'd3 || {R_time_out, G_time_out, B_time_out} !== 24'hffff00 || at_target !== 1'b0) begin
      n_fail++;
      $display("FAIL fade_start got %0d:%h at=%b want 3:ffff00 at=0", state, {R_time_out, G_time_out, B_time_out}, at_target);
    end
    for (int v = 254; v >= 0; v--) rq.push_back(8'(v));
    prev_r = R_time_out;
    t_at = -1; t_adv = -1;
    en = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (R_time_out !== prev_r) begin
        n_checks++;
        if (rq.size() == 0) begin
          n_fail++; $display("FAIL fade_extra_step got R=%h want no change", R_time_out);
        end else begin
          exp_r = rq.pop_front();
          if ({R_time_out, G_time_out, B_time_out} !== {exp_r, 8'hff, 8'h00}) begin
            n_fail++;
            $display("FAIL fade_step got %h want %h", {R_time_out, G_time_out, B_time_out}, {exp_r, 8'hff, 8'h00});
          end
        end
        prev_r = R_time_out;
      end
      if (t_at < 0 && at_target === 1'b1) t_at = c;
      if (t_adv < 0 && state === 3'd4) begin
        t_adv = c;
        fade_en = 1'b0;
      end
      if (t_adv > 0 && c == t_adv + 4) break;
    end
    en = 1'b0;
    n_checks++;
    if (t_at != 510) begin n_fail++; $display("FAIL fade_at_target_cycle got %0d want 510", t_at); end
    n_checks++;
    if (t_adv != 516) begin n_fail++; $display("FAIL fade_advance_cycle got %0d want 516", t_adv); end
    n_checks++;
    if (rq.size() != 0) begin n_fail++; $display("FAIL fade_steps_missing got %0d pending want 0", rq.size()); end
    n_checks++;
    if (state !== 3'd4 || {R_time_out, G_time_out, B_time_out} !== 24'h0000ff || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL fade_snap got %0d:%h at=%b want 4:0000ff at=1", state, {R_time_out, G_time_out, B_time_out}, at_target);
    end
    rq.delete();
  endtask

  task automatic test_pwm_duty;
    int   hr, hg, hb;
    logic prev, found;
    fade_en = 1'b0; en = 1'b0;
    step_pulse(); step_pulse(); step_pulse();
    n_checks++;
    if (state !== 3'd1 || {R_time_out, G_time_out, B_time_out} !== 24'hff6100) begin
      n_fail++; $display("FAIL pwm_setup got %0d:%h want 1:ff6100", state, {R_time_out, G_time_out, B_time_out});
    end
    repeat (520) @(negedge clk);
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
    end
    n_checks++;
    if (hr != 255 || hg != 97 || hb != 0) begin
      n_fail++; $display("FAIL pwm_duty_61 got %0d/%0d/%0d want 255/97/0", hr, hg, hb);
    end
    prev = pwm_g; found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (!prev && pwm_g) found = 1'b1;
      prev = pwm_g;
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL pwm_period_start got %b want 1", found); end
    repeat (150) @(negedge clk);
    step_req = 1'b1;
    hg = 0;
    for (int i = 151; i <= 254; i++) begin
      @(negedge clk);
      step_req = 1'b0;
      hg += int'(pwm_g);
    end
    n_checks++;
    if (hg != 0) begin n_fail++; $display("FAIL pwm_mid_period_change got %0d highs want 0", hg); end
    hg = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      hg += int'(pwm_g);
    end
    n_checks++;
    if (hg != 255 || state !== 3'd2) begin
      n_fail++; $display("FAIL pwm_next_period got %0d highs state %0d want 255 state 2", hg, state);
    end
  endtask

  task automatic test_step_tick;
    fade_en = 1'b0;
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 6) begin
        step_req = 1'b0;
        n_checks++;
        if (state !== 3'd3 || {R_time_out, G_time_out, B_time_out} !== 24'h00ff00) begin
          n_fail++; $display("FAIL step_tick_single got %0d:%h want 3:00ff00", state, {R_time_out, G_time_out, B_time_out});
        end
      end
      if (c == 11) begin
        n_checks++;
        if (state !== 3'd3) begin n_fail++; $display("FAIL step_tick_hold got %0d want 3", state); end
      end
      if (c == 12) begin
        n_checks++;
        if (state !== 3'd4) begin n_fail++; $display("FAIL step_tick_restart got %0d want 4", state); end
      end
      if (c == 5) step_req = 1'b1;
    end
    en = 1'b0;
  endtask

  task automatic test_freeze;
    int  hr, hg, hb;
    logic moved;
    en = 1'b0; fade_en = 1'b0;
    step_pulse();
    n_checks++;
    if (state !== 3'd5) begin n_fail++; $display("FAIL step_while_disabled got %0d want 5", state); end
    moved = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (state !== 3'd5 || {R_time_out, G_time_out, B_time_out} !== 24'h7f1fff) moved = 1'b1;
    end
    n_checks++;
    if (moved !== 1'b0) begin n_fail++; $display("FAIL freeze_state got moved=%b want 0", moved); end
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b);
    end
    n_checks++;
    if (hr != 127 || hg != 31 || hb != 255) begin
      n_fail++; $display("FAIL freeze_pwm got %0d/%0d/%0d want 127/31/255", hr, hg, hb);
    end
  endtask

  task automatic test_reset_mid_fade;
    int hr;
    fade_en = 1'b1;
    step_pulse();
    en = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if ({R_time_out, G_time_out, B_time_out} !== 24'h930beb || state !== 3'd0) begin
      n_fail++; $display("FAIL mid_fade_duty got %0d:%h want 0:930beb", state, {R_time_out, G_time_out, B_time_out});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0 || {R_time_out, G_time_out, B_time_out} !== 24'hff0000 || at_target !== 1'b1 ||
        {pwm_r, pwm_g, pwm_b} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset got %0d:%h at=%b pwm=%b want 0:ff0000 at=1 pwm=000",
               state, {R_time_out, G_time_out, B_time_out}, at_target, {pwm_r, pwm_g, pwm_b});
    end
    en = 1'b0; fade_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hr = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      hr += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
    end
    n_checks++;
    if (hr != 0) begin n_fail++; $display("FAIL reset_first_period got %0d highs want 0", hr); end
    hr = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      hr += int'(pwm_r);
    end
    n_checks++;
    if (hr != 255 || {R_time_out, G_time_out, B_time_out} !== 24'hff0000) begin
      n_fail++; $display("FAIL reset_second_period got %0d highs duty %h want 255 ff0000", hr, {R_time_out, G_time_out, B_time_out});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_jump();
    test_fade();
    test_pwm_duty();
    test_step_tick();
    test_freeze();
    test_reset_mid_fade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
